mdio_link: RTL and testbench

MDIO_LINK -- requirements
Module: mdio_link

---
 rtl/mdio_pkg.sv | 24 ++
 rtl/mdio_mmd.sv | 93 +++++++++
 rtl/mdio_link.sv | 141 ++++++++++++++
 tb/tb_mdio_link.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// MDIO encodings, frame bit positions and station state type shared by station and device.
// Defining MDIO_PREAMBLE_EN adds a 32-bit all-ones preamble ahead of every frame.
package mdio_pkg;

  localparam logic [1:0] ST_C22   = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int BIT_HDR_LAST = 13;
  localparam int BIT_TA0      = 14;
  localparam int BIT_TA1      = 15;
  localparam int BIT_DATA0    = 16;
  localparam int BIT_LAST     = 31;

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE_BITS = 32;
`else
  localparam int PRE_BITS = 0;
`endif

  typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} stn_state_t;

endpackage

// File: rtl/mdio_mmd.sv
// MDIO device: decodes the station bit stream, answers reads and strobes writes.
// Latency: header fields one cycle after the bit-13 mdc rise, write strobe one cycle after the bit-31 rise.
// Backpressure: none; the device follows mdc and never stalls the station.
module mdio_mmd
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'b01110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        mdc,
  input  logic        mdio_line,
  input  logic [15:0] mmd_rd_data,
  output logic        mdio_in,
  output logic [1:0]  mmd_st,
  output logic [1:0]  mmd_op,
  output logic [4:0]  mmd_phyaddr,
  output logic [4:0]  mmd_regaddr,
  output logic [15:0] mmd_wr_data,
  output logic        mmd_wr_stb
);

  localparam int CW = 7;

  logic          mdc_q;
  logic          rise;
  logic [CW-1:0] rise_cnt;
  logic [CW-1:0] cur_bit;
  logic [CW-1:0] fb;
  logic [14:0]   sr;
  logic [13:0]   hdr;
  logic [15:0]   rd_shadow;
  logic          rd_resp;

  // rise_cnt has already advanced for the rest of the high phase, so pull it back to the bit in flight
  assign rise    = mdc & ~mdc_q;
  assign cur_bit = rise_cnt - CW'(mdc & mdc_q);
  assign fb      = cur_bit - CW'(PRE_BITS);
  assign hdr     = {sr[12:0], mdio_line};

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q       <= 1'b0;
      rise_cnt    <= '0;
      sr          <= '0;
      rd_shadow   <= '0;
      rd_resp     <= 1'b0;
      mmd_st      <= '0;
      mmd_op      <= '0;
      mmd_phyaddr <= '0;
      mmd_regaddr <= '0;
      mmd_wr_data <= '0;
      mmd_wr_stb  <= 1'b0;
    end else begin
      mdc_q      <= mdc;
      mmd_wr_stb <= 1'b0;
      if (!active) begin
        rise_cnt <= '0;
        rd_resp  <= 1'b0;
      end else if (rise) begin
        rise_cnt <= rise_cnt + CW'(1);
        sr       <= {sr[13:0], mdio_line};
        if (cur_bit == CW'(PRE_BITS + BIT_HDR_LAST)) begin
          mmd_st      <= hdr[13:12];
          mmd_op      <= hdr[11:10];
          mmd_phyaddr <= hdr[9:5];
          mmd_regaddr <= hdr[4:0];
          rd_resp     <= (hdr[13:12] == ST_C22) && (hdr[9:5] == PHY_ADDR) && (hdr[11:10] == OP_READ);
        end
        if (cur_bit == CW'(PRE_BITS + BIT_TA0))
          rd_shadow <= mmd_rd_data;
        if (cur_bit == CW'(PRE_BITS + BIT_LAST) && mmd_st == ST_C22 &&
            mmd_phyaddr == PHY_ADDR && mmd_op == OP_WRITE) begin
          mmd_wr_data <= {sr, mdio_line};
          mmd_wr_stb  <= 1'b1;
        end
      end
    end
  end

  // Line idles high; only an addressed read pulls TA low and returns data
  always_comb begin
    mdio_in = 1'b1;
    if (active && rd_resp && cur_bit >= CW'(PRE_BITS + BIT_TA1)) begin
      if (fb == CW'(BIT_TA1))
        mdio_in = 1'b0;
      else
        mdio_in = rd_shadow[4'(CW'(BIT_LAST) - fb)];
    end
  end

endmodule

// File: rtl/mdio_link.sv
// MDIO station with loopback device (mdio_mmd); MDIO_PREAMBLE_EN prepends a 32-bit preamble.
// Latency: busy the cycle after start_stb, done after 32*MDC_DIV busy cycles (64*MDC_DIV with preamble).
// Backpressure: start_stb is only taken while idle; requests during a frame or its done cycle are dropped.
module mdio_link
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'b01110,
  parameter int          MDC_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stb,
  input  logic [1:0]  st,
  input  logic [1:0]  op,
  input  logic [4:0]  phyaddr,
  input  logic [4:0]  regaddr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        mdio_in,
  input  logic [15:0] mmd_rd_data,
  output logic [1:0]  mmd_st,
  output logic [1:0]  mmd_op,
  output logic [4:0]  mmd_phyaddr,
  output logic [4:0]  mmd_regaddr,
  output logic [15:0] mmd_wr_data,
  output logic        mmd_wr_stb
);

  localparam int DW   = $clog2(MDC_DIV);
  localparam int HALF = MDC_DIV / 2;

  stn_state_t    state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   frame_q;
  logic [15:0]   rd_sr;
  logic          bit_end, last_bit, is_read, mdc_hi, mdio_line;

  assign bit_end   = div_cnt == DW'(MDC_DIV - 1);
  assign last_bit  = bit_end && (bit_cnt == 5'd31);
  assign is_read   = frame_q[29:28] == OP_READ;
  assign mdc_hi    = div_cnt >= DW'(HALF);
  assign mdio_line = mdio_oe ? mdio_out : mdio_in;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_stb) begin
`ifdef MDIO_PREAMBLE_EN
        state_nxt = PRE;
`else
        state_nxt = SHIFT;
`endif
      end
      PRE:     if (last_bit) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mdc      = 1'b0;
    mdio_out = 1'b0;
    mdio_oe  = 1'b0;
    case (state)
      PRE: begin
        busy     = 1'b1;
        mdc      = mdc_hi;
        mdio_out = 1'b1;
        mdio_oe  = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        mdc  = mdc_hi;
        // Reads release the line from TA onward; the device owns it until the end of the frame
        if (!(is_read && bit_cnt >= 5'(BIT_TA0))) begin
          mdio_oe  = 1'b1;
          mdio_out = frame_q[5'd31 - bit_cnt];
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      frame_q <= '0;
      rd_sr   <= '0;
      rd_data <= '0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      if (start_stb)
        frame_q <= {st, op, phyaddr, regaddr, TA_WRITE, wr_data};
    end else if (busy) begin
      div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
      // bit_cnt wraps 31 -> 0 when the preamble hands over to the frame proper
      if (bit_end)
        bit_cnt <= bit_cnt + 5'd1;
      if (state == SHIFT && is_read && div_cnt == DW'(HALF) && bit_cnt >= 5'(BIT_DATA0))
        rd_sr <= {rd_sr[14:0], mdio_in};
      if (state == SHIFT && is_read && last_bit)
        rd_data <= rd_sr;
    end
  end

  mdio_mmd #(
    .PHY_ADDR(PHY_ADDR)
  ) u_mmd (
    .clk        (clk),
    .rst        (rst),
    .active     (busy),
    .mdc        (mdc),
    .mdio_line  (mdio_line),
    .mmd_rd_data(mmd_rd_data),
    .mdio_in    (mdio_in),
    .mmd_st     (mmd_st),
    .mmd_op     (mmd_op),
    .mmd_phyaddr(mmd_phyaddr),
    .mmd_regaddr(mmd_regaddr),
    .mmd_wr_data(mmd_wr_data),
    .mmd_wr_stb (mmd_wr_stb)
  );

endmodule

// File: tb/tb_mdio_link.sv
// Bench for mdio_link: frame-level reference model compared every cycle, plus directed literal checks.
module tb_mdio_link;

  localparam int         DIV = 4;
  localparam logic [4:0] PHY = 5'h0E;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif
  localparam int TOT   = (PRE + 32) * DIV;
  localparam int FLD_K = (PRE + 13) * DIV + DIV / 2 + 1;
  localparam int WS_K  = (PRE + 31) * DIV + DIV / 2 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stb = 1'b0;
  logic [1:0]  st = '0, op = '0;
  logic [4:0]  phyaddr = '0, regaddr = '0;
  logic [15:0] wr_data = '0, mmd_rd_data = '0;
  logic [15:0] rd_data, mmd_wr_data;
  logic        busy, done, mdc, mdio_out, mdio_oe, mdio_in, mmd_wr_stb;
  logic [1:0]  mmd_st, mmd_op;
  logic [4:0]  mmd_phyaddr, mmd_regaddr;

  always #5 clk = ~clk;

  mdio_link #(.PHY_ADDR(5'b01110), .MDC_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start_stb(start_stb), .st(st), .op(op),
    .phyaddr(phyaddr), .regaddr(regaddr), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .done(done), .mdc(mdc), .mdio_out(mdio_out), .mdio_oe(mdio_oe),
    .mdio_in(mdio_in), .mmd_rd_data(mmd_rd_data), .mmd_st(mmd_st), .mmd_op(mmd_op),
    .mmd_phyaddr(mmd_phyaddr), .mmd_regaddr(mmd_regaddr), .mmd_wr_data(mmd_wr_data),
    .mmd_wr_stb(mmd_wr_stb)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_k is the cycle offset inside the accepted frame (-1 idle, TOT = done cycle)
  int          m_k = -1;
  logic [1:0]  m_st = '0, m_op = '0;
  logic [4:0]  m_phy = '0, m_reg = '0;
  logic [15:0] m_wd = '0, m_rdv = '0;
  logic [15:0] e_rd_data = '0, e_wr_data = '0;
  logic [1:0]  e_st = '0, e_op = '0;
  logic [4:0]  e_phy = '0, e_reg = '0;
  logic        e_stb = 1'b0;

  always @(posedge clk) begin
    e_stb = 1'b0;
    if (rst) begin
      m_k = -1;
      e_rd_data = '0; e_wr_data = '0; e_st = '0; e_op = '0; e_phy = '0; e_reg = '0;
    end else if (m_k < 0) begin
      if (start_stb) begin
        m_st = st; m_op = op; m_phy = phyaddr; m_reg = regaddr; m_wd = wr_data; m_rdv = mmd_rd_data;
        m_k = 0;
      end
    end else if (m_k == TOT) begin
      m_k = -1;
    end else begin
      m_k++;
      if (m_k == FLD_K) begin
        e_st = m_st; e_op = m_op; e_phy = m_phy; e_reg = m_reg;
      end
      if (m_k == WS_K && m_st == 2'b01 && m_op == 2'b01 && m_phy == PHY) begin
        e_wr_data = m_wd;
        e_stb = 1'b1;
      end
      if (m_k == TOT && m_op == 2'b10)
        e_rd_data = (m_st == 2'b01 && m_phy == PHY) ? m_rdv : 16'hFFFF;
    end
  end

  // {busy, done, mdc, mdio_out, mdio_oe, mdio_in} for frame offset k
  function automatic logic [5:0] exp_live(int k);
    int b, fb;
    logic [31:0] w;
    logic out, oe, din, rd, resp, mdc_e;
    if (k < 0)    return 6'b000001;
    if (k == TOT) return 6'b010001;
    b     = k / DIV;
    mdc_e = (k % DIV) >= DIV / 2;
    w     = {m_st, m_op, m_phy, m_reg, 2'b10, m_wd};
    rd    = m_op == 2'b10;
    resp  = rd && m_st == 2'b01 && m_phy == PHY;
    out = 1'b1; oe = 1'b1; din = 1'b1;
    if (b >= PRE) begin
      fb = b - PRE;
      if (rd && fb >= 14) begin
        oe = 1'b0; out = 1'b0;
      end else begin
        out = w[31 - fb];
      end
      if (resp && fb == 15)      din = 1'b0;
      else if (resp && fb >= 16) din = m_rdv[31 - fb];
    end
    return {1'b1, 1'b0, mdc_e, out, oe, din};
  endfunction

  logic chk_en = 1'b0;
  logic busy_q = 1'b0;
  int   cyc = 0, t_busy = 0, t_done = 0;
  int   n_done = 0, n_stb = 0, n_oe_low = 0, n_in_low = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("live", {busy, done, mdc, mdio_out, mdio_oe, mdio_in}, exp_live(m_k));
      check("held", {rd_data, mmd_st, mmd_op, mmd_phyaddr, mmd_regaddr, mmd_wr_data, mmd_wr_stb},
                    {e_rd_data, e_st, e_op, e_phy, e_reg, e_wr_data, e_stb});
    end
    if (busy && !busy_q) t_busy = cyc;
    if (done) begin n_done++; t_done = cyc; end
    if (mmd_wr_stb) n_stb++;
    if (busy && !mdio_oe) n_oe_low++;
    if (busy && !mdio_in) n_in_low++;
    busy_q = busy;
  end

  task automatic frame(input logic [1:0] s, o, input logic [4:0] p, r,
                       input logic [15:0] wd, rv, input int mid);
    logic got;
    n_done = 0; n_stb = 0; n_oe_low = 0; n_in_low = 0;
    st = s; op = o; phyaddr = p; regaddr = r; wr_data = wd; mmd_rd_data = rv;
    start_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (m_k >= 0) break;
    end
    start_stb = 1'b0;
    st = 2'($urandom); op = 2'($urandom); phyaddr = 5'($urandom);
    regaddr = 5'($urandom); wr_data = 16'($urandom);
    if (mid > 0) begin
      repeat (mid) @(posedge clk);
      #1 start_stb = 1'b1;
      @(posedge clk);
      #1 start_stb = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < TOT + 8 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    check("done_seen", got, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_live", {busy, done, mdc, mdio_out, mdio_oe, mdio_in}, 6'b000001);
    check("reset_held", {rd_data, mmd_st, mmd_op, mmd_phyaddr, mmd_regaddr, mmd_wr_data, mmd_wr_stb}, 47'd0);

    // Addressed write
    frame(2'b01, 2'b01, 5'h0E, 5'h0D, 16'h3F7F, 16'h0000, 0);
    @(negedge clk);
    check("wr_latency", t_done - t_busy, TOT);
    check("wr_data", mmd_wr_data, 16'h3F7F);
    check("wr_regaddr", mmd_regaddr, 5'h0D);
    check("wr_stb_count", n_stb, 1);
    check("wr_oe_low_cycles", n_oe_low, 0);
    check("wr_done_count", n_done, 1);

    // Addressed read: 18 released bits x 4 cycles; TA plus ten zero data bits of 4534 held low
    frame(2'b01, 2'b10, 5'h0E, 5'h03, 16'h0000, 16'h4534, 0);
    @(negedge clk);
    check("rd_data", rd_data, 16'h4534);
    check("rd_oe_low_cycles", n_oe_low, 72);
    check("rd_in_low_cycles", n_in_low, 44);

    // Read of an absent PHY
    frame(2'b01, 2'b10, 5'h05, 5'h03, 16'h0000, 16'hA5A5, 0);
    @(negedge clk);
    check("noresp_rd_data", rd_data, 16'hFFFF);
    check("noresp_in_low_cycles", n_in_low, 0);

    // Start strobe mid-frame
    frame(2'b01, 2'b01, 5'h0E, 5'h11, 16'h1234, 16'h0000, 40);
    @(negedge clk);
    check("mid_done_count", n_done, 1);
    check("mid_stb_count", n_stb, 1);
    check("mid_wr_data", mmd_wr_data, 16'h1234);

    // Reset during bit 20 of a write
    @(posedge clk);
    #1;
    n_done = 0; n_stb = 0;
    st = 2'b01; op = 2'b01; phyaddr = 5'h0E; regaddr = 5'h0D; wr_data = 16'h3F7F;
    start_stb = 1'b1;
    @(posedge clk);
    #1 start_stb = 1'b0;
    for (int i = 0; i < TOT; i++) begin
      if (m_k == (PRE + 20) * DIV) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_live", {busy, done, mdc, mdio_out, mdio_oe, mdio_in}, 6'b000001);
    check("abort_held", {rd_data, mmd_st, mmd_op, mmd_phyaddr, mmd_regaddr, mmd_wr_data, mmd_wr_stb}, 47'd0);
    repeat (TOT + 8) @(negedge clk);
    check("abort_stb_count", n_stb, 0);
    check("abort_done_count", n_done, 0);

    // Randomised frames, some back-to-back, some with stray start strobes
    for (int n = 0; n < 40; n++) begin
      logic [1:0] s, o;
      logic [4:0] p;
      int mid;
      s   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      o   = 2'($urandom);
      p   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : PHY;
      mid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOT - 10)) : 0;
      frame(s, o, p, 5'($urandom), 16'($urandom), 16'($urandom), mid);
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
